// File: rtl/fir_driver_pkg.sv
// Shared types and constants for the FIR filter driver.
// FIR_DRIVER_TIMEOUT_EN enables the wait-state watchdog in fir_driver.
package fir_driver_pkg;
  localparam int NUM_COEFF  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 16;
  localparam int IDX_W      = $clog2(NUM_COEFF);

  localparam logic [7:0] HI_LIMIT = 8'd7;
  localparam logic [7:0] LO_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    IDLE, C_PULSE, C_WAIT_HI, C_WAIT_LO, S_PULSE, S_WAIT_HI, S_WAIT_LO, CAPTURE
  } state_t;

  function automatic logic in_coeff_phase(state_t s);
    return (s == C_PULSE) || (s == C_WAIT_HI) || (s == C_WAIT_LO);
  endfunction
endpackage

// File: rtl/fir_driver_if.sv
// Host and filter-side signals of fir_driver; master is the driver's view.
interface fir_driver_if;
  import fir_driver_pkg::*;

  logic              coeff_wr;
  logic [IDX_W-1:0]  coeff_idx;
  logic [DATA_W-1:0] coeff_in;
  logic              coeff_go;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              sample_ready;
  logic              load_coeff;
  logic [DATA_W-1:0] fir_coefficient;
  logic              data_ready;
  logic [DATA_W-1:0] sample_data;
  logic              modwait;
  logic              err;
  logic [DATA_W-1:0] fir_out;
  logic              result_valid;
  logic [DATA_W-1:0] result;
  logic              result_err;
  logic              busy;
  logic              timeout;

  modport master (
    input  coeff_wr, coeff_idx, coeff_in, coeff_go, sample_valid, sample_in,
           modwait, err, fir_out,
    output sample_ready, load_coeff, fir_coefficient, data_ready, sample_data,
           result_valid, result, result_err, busy, timeout
  );

  modport slave (
    output coeff_wr, coeff_idx, coeff_in, coeff_go, sample_valid, sample_in,
           modwait, err, fir_out,
    input  sample_ready, load_coeff, fir_coefficient, data_ready, sample_data,
           result_valid, result, result_err, busy, timeout
  );
endinterface

// File: rtl/fir_driver_sample_fifo.sv
// Sample FIFO (power-of-two depth) with a registered ready flag (count < DEPTH).
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // ready tracks the post-update occupancy so it is valid the cycle after a push
      ready <= (count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fir_driver.sv
// Sequences coefficient loads and sample pushes into a handshaking FIR filter.
// Define FIR_DRIVER_TIMEOUT_EN to add the wait-state watchdog and sticky timeout.
module fir_driver
  import fir_driver_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  fir_driver_if.master bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF-1);

  state_t                          state, state_next;
  logic [IDX_W-1:0]                idx, idx_next;
  logic [NUM_COEFF-1:0][DATA_W-1:0] coeff_buf;
  logic                            push, pop, full, empty, ready, expire;
  logic [DATA_W-1:0]               fifo_dout;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                            count_unused;

  assign push             = bus.sample_valid && ready && !full;
  assign bus.sample_ready = ready;
  assign bus.busy         = (state != IDLE);
  assign count_unused     = ^fifo_count;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.sample_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .ready (ready),
    .count (fifo_count)
  );

`ifdef FIR_DRIVER_TIMEOUT_EN
  logic [7:0] wdog;
  logic       timeout_q;
  logic       in_hi, in_lo;

  assign in_hi  = (state == C_WAIT_HI) || (state == S_WAIT_HI);
  assign in_lo  = (state == C_WAIT_LO) || (state == S_WAIT_LO);
  assign expire = (in_hi && !bus.modwait && wdog == HI_LIMIT) ||
                  (in_lo &&  bus.modwait && wdog == LO_LIMIT);
  assign bus.timeout = timeout_q;

  // wdog holds the number of completed cycles in the current wait state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog <= ((in_hi || in_lo) && state_next == state) ? wdog + 8'd1 : 8'd0;
      if (expire) timeout_q <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.coeff_go) begin
          state_next = C_PULSE;
          idx_next   = '0;
        end else if (!empty) begin
          pop        = 1'b1;
          state_next = S_PULSE;
        end
      end
      C_PULSE:   state_next = C_WAIT_HI;
      C_WAIT_HI: if (bus.modwait) state_next = C_WAIT_LO;
      C_WAIT_LO: begin
        if (!bus.modwait) begin
          idx_next   = idx + 1'b1;
          state_next = (idx < LAST_IDX) ? C_PULSE : IDLE;
        end
      end
      S_PULSE:   state_next = S_WAIT_HI;
      S_WAIT_HI: if (bus.modwait) state_next = S_WAIT_LO;
      S_WAIT_LO: if (!bus.modwait) state_next = CAPTURE;
      CAPTURE:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    // a stalled filter abandons the transaction; unloaded coefficients are dropped
    if (expire) begin
      state_next = IDLE;
      idx_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      idx                 <= '0;
      coeff_buf           <= '0;
      bus.load_coeff      <= 1'b0;
      bus.fir_coefficient <= '0;
      bus.data_ready      <= 1'b0;
      bus.sample_data     <= '0;
      bus.result_valid    <= 1'b0;
      bus.result          <= '0;
      bus.result_err      <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (bus.coeff_wr && !in_coeff_phase(state))
        coeff_buf[bus.coeff_idx] <= bus.coeff_in;
      // pulse outputs are registered from the next state so they align with *_PULSE
      bus.load_coeff <= (state_next == C_PULSE);
      if (state_next == C_PULSE) bus.fir_coefficient <= coeff_buf[idx_next];
      bus.data_ready <= (state_next == S_PULSE);
      if (pop) bus.sample_data <= fifo_dout;
      bus.result_valid <= (state == CAPTURE);
      if (state == CAPTURE) begin
        bus.result     <= bus.fir_out;
        bus.result_err <= bus.err;
      end
    end
  end
endmodule

// File: tb/tb_fir_driver.sv
// Self-checking bench for fir_driver: filter model, directed vectors and random traffic.
module tb_fir_driver;
  import fir_driver_pkg::*;

  logic clk, reset;
  fir_driver_if bus();

  fir_driver dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  int hold = 3, cnt = 0;
  bit mw_stuck = 0, mw_never = 0, fo_auto = 0;
  logic [15:0] fo_val = '0;
  logic        fo_err = 1'b0;
  logic [15:0] ld_q[$], dr_q[$];
  logic [16:0] res_q[$];
  int          ev_q[$];

  typedef struct {
    logic [15:0] sample, fo;
    logic        ferr;
    logic [15:0] exp_data, exp_res;
    logic        exp_err;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [15:0] fo_fn(input logic [15:0] s);
    return s * 16'd3 + 16'h0101;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // filter model: modwait rises after each pulse and stays high for `hold` cycles
  initial begin
    bus.modwait = 0; bus.err = 0; bus.fir_out = '0;
    forever begin
      @(negedge clk);
      if (bus.load_coeff || bus.data_ready) begin
        cnt = hold;
        if (bus.data_ready) begin
          bus.fir_out = fo_auto ? fo_fn(bus.sample_data) : fo_val;
          bus.err     = fo_auto ? ^bus.sample_data : fo_err;
        end
      end else if (cnt > 0) cnt--;
      bus.modwait = mw_stuck || (!mw_never && cnt > 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.load_coeff)   begin ld_q.push_back(bus.fir_coefficient); ev_q.push_back(1); end
      if (bus.data_ready)   begin dr_q.push_back(bus.sample_data); ev_q.push_back(2); end
      if (bus.result_valid) res_q.push_back({bus.result_err, bus.result});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sample_ready"}, 32'(bus.sample_ready), 1);
    chk({tag, " load_coeff"}, 32'(bus.load_coeff), 0);
    chk({tag, " data_ready"}, 32'(bus.data_ready), 0);
    chk({tag, " fir_coefficient"}, 32'(bus.fir_coefficient), 0);
    chk({tag, " sample_data"}, 32'(bus.sample_data), 0);
    chk({tag, " result"}, 32'(bus.result), 0);
    chk({tag, " result_err"}, 32'(bus.result_err), 0);
    chk({tag, " result_valid"}, 32'(bus.result_valid), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " timeout"}, 32'(bus.timeout), 0);
  endtask

  task automatic clear_q();
    ld_q.delete(); dr_q.delete(); res_q.delete(); ev_q.delete();
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int q = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      q = bus.busy ? 0 : q + 1;
      if (q >= 3) return;
    end
    checks++; errors++;
    $display("FAIL %s: still busy after %0d cycles", nm, budget);
  endtask

  task automatic wr_coeff(input logic [1:0] i, input logic [15:0] v);
    @(negedge clk);
    bus.coeff_wr = 1; bus.coeff_idx = i; bus.coeff_in = v;
    @(negedge clk);
    bus.coeff_wr = 0;
  endtask

  task automatic go();
    @(negedge clk); bus.coeff_go = 1;
    @(negedge clk); bus.coeff_go = 0;
  endtask

  task automatic push1(input logic [15:0] s);
    @(negedge clk); bus.sample_valid = 1; bus.sample_in = s;
    @(negedge clk); bus.sample_valid = 0;
  endtask

  logic [15:0] cb[4];
  logic [15:0] acc[$];
  int          n_acc;
  logic        rdy5;

  initial begin
    reset = 1;
    bus.coeff_wr = 0; bus.coeff_idx = '0; bus.coeff_in = '0; bus.coeff_go = 0;
    bus.sample_valid = 0; bus.sample_in = '0;
    vecs[0] = '{16'h1234, 16'h0ABC, 1'b0, 16'h1234, 16'h0ABC, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[3] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE, 1'b1};
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset = 0;

    // coefficient load in order, with a write and a go attempted mid-load
    for (int i = 0; i < 4; i++) wr_coeff(2'(i), 16'(i + 1));
    clear_q();
    go();
    chk("go_latency load_coeff", 32'(bus.load_coeff), 1);
    chk("go_latency fir_coefficient", 32'(bus.fir_coefficient), 1);
    @(negedge clk); @(negedge clk);
    bus.coeff_wr = 1; bus.coeff_idx = 2'd3; bus.coeff_in = 16'hDEAD; bus.coeff_go = 1;
    @(negedge clk);
    bus.coeff_wr = 0; bus.coeff_go = 0;
    wait_idle(300, "coeff_load");
    chk("coeff load count", ld_q.size(), 4);
    if (ld_q.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("coeff order %0d", i), 32'(ld_q[i]), i + 1);
    chk("coeff busy after", 32'(bus.busy), 0);
    chk("coeff hold value", 32'(bus.fir_coefficient), 4);
    chk("coeff load low", 32'(bus.load_coeff), 0);

    // single-sample vectors
    for (int k = 0; k < 4; k++) begin
      fo_auto = 0; fo_val = vecs[k].fo; fo_err = vecs[k].ferr;
      clear_q();
      @(negedge clk); bus.sample_valid = 1; bus.sample_in = vecs[k].sample;
      @(negedge clk); bus.sample_valid = 0;
      @(negedge clk);
      chk($sformatf("vec%0d pop latency", k), 32'(bus.data_ready), 1);
      wait_idle(300, "vec");
      chk($sformatf("vec%0d data_ready count", k), dr_q.size(), 1);
      if (dr_q.size() == 1) chk($sformatf("vec%0d sample_data", k), 32'(dr_q[0]), 32'(vecs[k].exp_data));
      chk($sformatf("vec%0d result_valid count", k), res_q.size(), 1);
      if (res_q.size() == 1)
        chk($sformatf("vec%0d result", k), 32'(res_q[0]), {15'd0, vecs[k].exp_err, vecs[k].exp_res});
      chk($sformatf("vec%0d result held", k), 32'(bus.result), 32'(vecs[k].exp_res));
    end

    // coeff_go and a sample in the same idle cycle: coefficients first
    clear_q();
    @(negedge clk);
    bus.coeff_go = 1; bus.sample_valid = 1; bus.sample_in = 16'h5A5A;
    @(negedge clk);
    bus.coeff_go = 0; bus.sample_valid = 0;
    wait_idle(300, "priority");
    chk("priority event count", ev_q.size(), 5);
    if (ev_q.size() == 5)
      for (int i = 0; i < 5; i++) chk($sformatf("priority event %0d", i), ev_q[i], (i < 4) ? 1 : 2);

    // FIFO fill while the filter is stalled
    clear_q();
    mw_stuck = 1;
    push1(16'h1000);
    repeat (4) @(negedge clk);
    n_acc = 0; rdy5 = 1'bx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.sample_valid = 1; bus.sample_in = 16'h2000 + 16'(i);
      if (i == 4) rdy5 = bus.sample_ready;
      if (bus.sample_ready) n_acc++;
    end
    @(negedge clk); bus.sample_valid = 0;
    chk("full accepted", n_acc, 4);
    chk("full ready on 5th", 32'(rdy5), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("full ready held %0d", i), 32'(bus.sample_ready), 0);
    end
    chk("full one data_ready", dr_q.size(), 1);
    mw_stuck = 0;
    wait_idle(400, "full_drain");
    chk("full drain count", dr_q.size(), 5);
    if (dr_q.size() == 5) begin
      chk("full drain first", 32'(dr_q[0]), 32'h1000);
      for (int i = 0; i < 4; i++) chk($sformatf("full drain %0d", i), 32'(dr_q[i+1]), 32'h2000 + i);
    end
    chk("full results", res_q.size(), 5);
    chk("full ready after", 32'(bus.sample_ready), 1);

    // reset while waiting for modwait to fall
    clear_q();
    mw_stuck = 1;
    push1(16'h7777); push1(16'h8888); push1(16'h9999);
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1 chk_reset("mid_reset");
    @(negedge clk);
    reset = 0; mw_stuck = 0;
    repeat (10) @(negedge clk);
    chk("mid_reset no result", res_q.size(), 0);
    chk("mid_reset fifo empty", dr_q.size(), 1);
    chk("mid_reset busy", 32'(bus.busy), 0);
    chk("mid_reset ready", 32'(bus.sample_ready), 1);
    clear_q();
    go();
    wait_idle(300, "zero_coeff");
    chk("zero coeff count", ld_q.size(), 4);
    if (ld_q.size() == 4) chk("zero coeff values", 32'(ld_q[0] | ld_q[1] | ld_q[2] | ld_q[3]), 0);

`ifdef FIR_DRIVER_TIMEOUT_EN
    clear_q();
    mw_never = 1;
    go();
    repeat (8) @(negedge clk);
    chk("timeout not yet", 32'(bus.timeout), 0);
    @(negedge clk);
    chk("timeout set", 32'(bus.timeout), 1);
    chk("timeout idle", 32'(bus.busy), 0);
    repeat (20) @(negedge clk);
    mw_never = 0;
    chk("timeout sticky", 32'(bus.timeout), 1);
    chk("timeout dropped loads", ld_q.size(), 1);
    chk("timeout no result", res_q.size(), 0);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    chk("timeout cleared", 32'(bus.timeout), 0);
`else
    chk("timeout tied", 32'(bus.timeout), 0);
`endif

    // random traffic against a queue-based reference
    fo_auto = 1;
    for (int i = 0; i < 4; i++) cb[i] = '0;
    for (int it = 0; it < 30; it++) begin
      hold = $urandom_range(2, 5);
      clear_q();
      if ($urandom_range(0, 2) == 0) begin
        for (int w = 0; w < $urandom_range(1, 4); w++) begin
          logic [1:0]  s;
          logic [15:0] v;
          s = 2'($urandom_range(0, 3)); v = 16'($urandom);
          cb[s] = v;
          wr_coeff(s, v);
        end
        go();
        wait_idle(400, "rand_coeff");
        chk($sformatf("rand%0d load count", it), ld_q.size(), 4);
        if (ld_q.size() == 4)
          for (int i = 0; i < 4; i++) chk($sformatf("rand%0d coeff %0d", it, i), 32'(ld_q[i]), 32'(cb[i]));
      end else begin
        acc.delete();
        for (int c = 0; c < $urandom_range(6, 16); c++) begin
          @(negedge clk);
          bus.sample_valid = 1'($urandom_range(0, 1));
          bus.sample_in = 16'($urandom);
          if (bus.sample_valid && bus.sample_ready) acc.push_back(bus.sample_in);
        end
        @(negedge clk); bus.sample_valid = 0;
        wait_idle(800, "rand_samples");
        chk($sformatf("rand%0d sample count", it), dr_q.size(), acc.size());
        chk($sformatf("rand%0d result count", it), res_q.size(), acc.size());
        if (dr_q.size() == acc.size() && res_q.size() == acc.size())
          for (int i = 0; i < acc.size(); i++) begin
            chk($sformatf("rand%0d sample %0d", it, i), 32'(dr_q[i]), 32'(acc[i]));
            chk($sformatf("rand%0d result %0d", it, i), 32'(res_q[i]), {15'd0, ^acc[i], fo_fn(acc[i])});
          end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_driver.md
FIR_DRIVER -- requirements
Module: fir_driver

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock, all state on rising edge.
REQ-002 The block SHALL have these ports: reset  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have these ports: coeff_wr  in  1, coeff_idx  in  2, coeff_in  in  16 -- host write of one coefficient into buffer slot coeff_idx.
REQ-004 The block SHALL have these ports: coeff_go  in  1  host request to load all 4 buffered coefficients into the filter.
REQ-005 The block SHALL have these ports: sample_valid  in  1, sample_in  in  16, sample_ready  out  1 -- host sample push (valid/ready).
REQ-006 The block SHALL have these ports: load_coeff  out  1, fir_coefficient  out  16, data_ready  out  1, sample_data  out  16 -- filter-side drive.
REQ-007 The block SHALL have these ports: modwait  in  1, err  in  1, fir_out  in  16 -- filter-side status and result.
REQ-008 The block SHALL have these ports: result_valid  out  1, result  out  16, result_err  out  1, busy  out  1, timeout  out  1.

Function
REQ-009 FSM states SHALL be IDLE, C_PULSE, C_WAIT_HI, C_WAIT_LO, S_PULSE, S_WAIT_HI, S_WAIT_LO, CAPTURE.
REQ-010 In IDLE, coeff_go SHALL take priority over a non-empty FIFO: IDLE->C_PULSE with index 0; else FIFO non-empty: pop and go to S_PULSE.
REQ-011 In C_PULSE, load_coeff SHALL be 1 for exactly one cycle with fir_coefficient = buffer[index]; the next state SHALL be C_WAIT_HI.
REQ-012 C_WAIT_HI SHALL wait for modwait==1 and then go to C_WAIT_LO; C_WAIT_LO SHALL wait for modwait==0.
REQ-013 On leaving C_WAIT_LO, the index SHALL increment, return to C_PULSE if index<3, else go to IDLE; the load order SHALL be slot 0,1,2,3.
REQ-014 In S_PULSE, data_ready SHALL be 1 for exactly one cycle with sample_data = popped word; it SHALL then go to S_WAIT_HI and then S_WAIT_LO with the same rules as coefficients.
REQ-015 On modwait falling in S_WAIT_LO, the FSM SHALL go to CAPTURE; CAPTURE SHALL register result<=fir_out and result_err<=err, pulse result_valid for one cycle, and return to IDLE.
REQ-016 fir_coefficient and sample_data SHALL hold their last driven value outside pulse cycles; load_coeff and data_ready SHALL be 0 outside pulse cycles.
REQ-017 The sample FIFO SHALL be 4 deep × 16 bits; sample_ready SHALL be registered and equal to (count<4); a push SHALL occur iff sample_valid && sample_ready.
REQ-018 A simultaneous push and pop SHALL leave count unchanged; a push when full SHALL be impossible by construction; a pop when empty SHALL never occur.
REQ-019 coeff_wr SHALL be ignored while in any C_* state; it SHALL be accepted in all other states.
REQ-020 coeff_go SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Worst-case latency SHALL be: coeff_go to first load_coeff = 1 cycle; FIFO pop to data_ready = 1 cycle.

Reset
REQ-023 reset SHALL asynchronously force IDLE, index 0, FIFO empty, and coefficient buffer all zero.
REQ-024 reset SHALL force these outputs: sample_ready=1, load_coeff=0, data_ready=0, fir_coefficient=0, sample_data=0, result=0, result_err=0, result_valid=0, busy=0, timeout=0.
REQ-025 A reset asserted mid-transaction SHALL abandon it with no result_valid pulse.

Configuration
REQ-026 With FIR_DRIVER_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles in each *_WAIT_HI/*_WAIT_LO state.
REQ-027 With FIR_DRIVER_TIMEOUT_EN defined, exceeding 7 cycles in WAIT_HI or 255 cycles in WAIT_LO SHALL set sticky timeout=1 and return to IDLE; in that case no result_valid SHALL pulse and the remaining coefficients SHALL be dropped.
REQ-028 timeout SHALL clear only on reset.
REQ-029 Without FIR_DRIVER_TIMEOUT_EN, the WAIT states SHALL wait indefinitely, timeout SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-030 A package fir_driver_pkg SHALL hold the state enum, NUM_COEFF=4, FIFO_DEPTH=4, DATA_W=16, and the HI_LIMIT=7/LO_LIMIT=255 constants.
REQ-031 The FIFO SHALL be a sub-module named sample_fifo (push/pop/full/empty/count); the FSM, coefficient buffer and capture logic SHALL stay in fir_driver.

Verification
REQ-032 Write 0x0001,0x0002,0x0003,0x0004 to slots 0-3, then pulse coeff_go, with a filter model holding modwait high 3 cycles after each load -> exactly 4 load_coeff pulses carrying 1,2,3,4 in order, busy low afterwards.
REQ-033 Push 0x1234 with model fir_out=0x0ABC, err=0 -> one data_ready with sample_data=0x1234, then result=0x0ABC, result_err=0, one result_valid pulse.
REQ-034 Push 5 samples back-to-back while modwait is stuck high -> 4 accepted, sample_ready=0 on the 5th, count holds at 4 until the first pop.
REQ-035 Assert coeff_go and sample_valid in the same IDLE cycle -> all 4 coefficients load before the sample's data_ready.
REQ-036 Assert reset during S_WAIT_LO -> all outputs at reset values, FIFO empty, and no result_valid pulse.
REQ-037 With FIR_DRIVER_TIMEOUT_EN defined and modwait never rising -> timeout=1 on the 8th WAIT_HI cycle, FSM in IDLE, and timeout stays 1 until reset.
